// File: rtl/potato1_datapath.sv
// rtl/potato1_datapath.sv - Potato-1 datapath: program memory, PC, data pointer, tape and byte I/O
module potato1_datapath #(
  parameter int PROG_AW = 6,
  parameter int DATA_AW = 4,
  parameter int DATA_W  = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [7:0]         Command,
  output logic [3:0]         Instruction,
  output logic               State,
  output logic               IOReady,
  input  logic               Load_En,
  input  logic [PROG_AW-1:0] Load_Addr,
  input  logic [3:0]         Load_Data,
  output logic [DATA_W-1:0]  Out_Data,
  output logic               Out_Valid,
  input  logic               Out_Ready,
  input  logic [DATA_W-1:0]  In_Data,
  input  logic               In_Valid,
  output logic               In_Ready
);

  localparam int PROG_DEPTH = 1 << PROG_AW;
  localparam int TAPE_DEPTH = 1 << DATA_AW;

  typedef enum logic [1:0] {IDLE, PUT_WAIT, GET_WAIT, DONE} io_state_t;

  logic [3:0]         prog [PROG_DEPTH];
  logic [DATA_W-1:0]  tape [TAPE_DEPTH];
  logic [PROG_AW-1:0] pc;
  logic [DATA_AW-1:0] x;
  io_state_t          state, state_nxt;

  logic [7:0] cmd;
  logic       pc_inc, pc_dec, x_inc, x_dec, a_inc, a_dec;
  logic       put_start, get_done;

  // Load mode masks the control unit completely.
  assign cmd    = Load_En ? 8'h00 : Command;
  assign pc_inc = cmd[0] & ~cmd[1];
  assign pc_dec = cmd[1] & ~cmd[0];
  assign x_inc  = cmd[2] & ~cmd[3];
  assign x_dec  = cmd[3] & ~cmd[2];
  assign a_inc  = cmd[4] & ~cmd[5];
  assign a_dec  = cmd[5] & ~cmd[4];

  always_ff @(posedge Clock) begin
    if (Load_En) begin
      prog[Load_Addr] <= Load_Data;
    end
  end

  assign Instruction = Load_En ? 4'b1111 : prog[pc];
  assign State       = (tape[x] == '0);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc <= '0;
    end else if (Load_En) begin
      pc <= '0;
    end else if (pc_inc) begin
      pc <= pc + PROG_AW'(1);
    end else if (pc_dec) begin
      pc <= pc - PROG_AW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      x <= '0;
    end else if (x_inc) begin
      x <= x + DATA_AW'(1);
    end else if (x_dec) begin
      x <= x - DATA_AW'(1);
    end
  end

  // Cell ops use the pre-update X, so a same-cycle X move does not redirect them.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < TAPE_DEPTH; i++) begin
        tape[i] <= '0;
      end
    end else if (get_done) begin
      tape[x] <= In_Data;
    end else if (a_inc) begin
      tape[x] <= tape[x] + DATA_W'(1);
    end else if (a_dec) begin
      tape[x] <= tape[x] - DATA_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    put_start = 1'b0;
    get_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd[6]) begin
          state_nxt = PUT_WAIT;
          put_start = 1'b1;
        end else if (cmd[7]) begin
          state_nxt = GET_WAIT;
        end
      end
      PUT_WAIT: begin
        if (Out_Ready) begin
          state_nxt = DONE;
        end
      end
      GET_WAIT: begin
        if (In_Valid) begin
          state_nxt = DONE;
          get_done  = 1'b1;
        end
      end
      DONE: begin
        // Control unit has moved on once the request bits drop or the PC steps.
        if (cmd[7:6] == 2'b00 || cmd[1:0] != 2'b00) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Out_Data <= '0;
    end else if (put_start) begin
      Out_Data <= tape[x];
    end
  end

  assign Out_Valid = (state == PUT_WAIT);
  assign In_Ready  = (state == GET_WAIT);
  assign IOReady   = (state == DONE);

endmodule

// File: tb/tb_potato1_datapath.sv
// tb/tb_potato1_datapath.sv - randomized and directed checks of potato1_datapath against a behavioural model
module tb_potato1_datapath;
  localparam int PD = 64;
  localparam int TD = 16;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] Command = 8'h00;
  logic [3:0] Instruction;
  logic       State, IOReady;
  logic       Load_En = 1'b0;
  logic [5:0] Load_Addr = '0;
  logic [3:0] Load_Data = '0;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic       Out_Ready = 1'b0;
  logic [7:0] In_Data = '0;
  logic       In_Valid = 1'b0;
  logic       In_Ready;

  potato1_datapath #(.PROG_AW(6), .DATA_AW(4), .DATA_W(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Command(Command), .Instruction(Instruction),
    .State(State), .IOReady(IOReady), .Load_En(Load_En), .Load_Addr(Load_Addr),
    .Load_Data(Load_Data), .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready)
  );

  always #5 Clock = ~Clock;

  int ncmp = 0;
  int nerr = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model phases: 0 idle, 1 waiting on sink, 2 waiting on source, 3 transfer done
  int m_pc, m_x, m_ph, m_od;
  int m_tape [TD];
  int m_prog [PD];
  bit m_pk [PD];
  int mc, mxo;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      m_pc = 0; m_x = 0; m_ph = 0; m_od = 0;
      for (int i = 0; i < TD; i++) m_tape[i] = 0;
    end else begin
      mc  = Load_En ? 0 : int'(Command);
      mxo = m_x;
      if (Load_En) begin
        m_prog[Load_Addr] = int'(Load_Data);
        m_pk[Load_Addr] = 1'b1;
      end
      case (m_ph)
        0: if (mc[6]) begin m_od = m_tape[mxo]; m_ph = 1; end
           else if (mc[7]) m_ph = 2;
        1: if (Out_Ready) m_ph = 3;
        2: if (In_Valid) begin m_tape[mxo] = int'(In_Data); m_ph = 3; end
        default: if ((mc & 'hC0) == 0 || (mc & 3) != 0) m_ph = 0;
      endcase
      m_tape[mxo] = (m_tape[mxo] + int'(mc[4]) - int'(mc[5]) + 256) % 256;
      m_x  = (m_x + int'(mc[2]) - int'(mc[3]) + TD) % TD;
      m_pc = Load_En ? 0 : (m_pc + int'(mc[0]) - int'(mc[1]) + PD) % PD;
    end
  end

  always @(negedge Clock) begin
    if (armed) begin
      if (Load_En || m_pk[m_pc]) chk("instruction", int'(Instruction), Load_En ? 15 : m_prog[m_pc]);
      chk("state", int'(State), int'(m_tape[m_x] == 0));
      chk("ioready", int'(IOReady), int'(m_ph == 3));
      chk("out_valid", int'(Out_Valid), int'(m_ph == 1));
      chk("in_ready", int'(In_Ready), int'(m_ph == 2));
      chk("out_data", int'(Out_Data), m_od);
    end
  end

  task automatic cyc(input logic [7:0] c);
    Command = c;
    @(posedge Clock);
    #2;
  endtask

  int ld_cnt;
  int r;
  logic [3:0] first4 [4];

  initial begin
    first4 = '{4'd0, 4'd2, 4'd2, 4'd4};
    @(posedge Clock); #2;
    armed = 1'b1;
    cyc(8'h00);
    chk("rst_out_valid", int'(Out_Valid), 0);
    chk("rst_ioready", int'(IOReady), 0);
    chk("rst_in_ready", int'(In_Ready), 0);
    chk("rst_out_data", int'(Out_Data), 0);
    chk("rst_state", int'(State), 1);
    Reset_n = 1'b1;

    Load_En = 1'b1;
    for (int i = 0; i < PD; i++) begin
      Load_Addr = 6'(i);
      Load_Data = (i < 4) ? first4[i] : 4'(i % 16);
      cyc(8'h01);
      if (i == 10) chk("load_halt", int'(Instruction), 15);
    end
    Load_En = 1'b0;
    #1 chk("instr_pc0", int'(Instruction), 0);
    repeat (4) cyc(8'h01);
    chk("instr_pc4", int'(Instruction), 4);

    chk("state_cell0_zero", int'(State), 1);
    cyc(8'h20);
    chk("a_dec_wrap_state", int'(State), 0);
    cyc(8'h10);
    chk("a_inc_wrap_state", int'(State), 1);

    cyc(8'h08); chk("x15_zero", int'(State), 1);
    cyc(8'h10); chk("x15_one", int'(State), 0);
    cyc(8'h04); chk("x_wrap_to0", int'(State), 1);
    cyc(8'h08); chk("x_wrap_to15", int'(State), 0);
    cyc(8'h0C); chk("x_both_hold", int'(State), 0);
    cyc(8'h20); chk("x15_cleared", int'(State), 1);
    cyc(8'h04);

    repeat (5) cyc(8'h02);
    chk("pc_wrap_63", int'(Instruction), 15);
    cyc(8'h02); chk("pc_62", int'(Instruction), 14);
    cyc(8'h01); cyc(8'h01);
    chk("pc_wrap_0", int'(Instruction), 0);
    cyc(8'h03); chk("pc_both_hold", int'(Instruction), 0);

    repeat (3) cyc(8'h04);
    repeat (65) cyc(8'h10);
    chk("cell3_nonzero", int'(State), 0);
    Out_Ready = 1'b0;
    cyc(8'h40);
    chk("put_valid", int'(Out_Valid), 1);
    chk("put_data", int'(Out_Data), 8'h41);
    repeat (5) begin
      cyc(8'h40);
      chk("put_hold_valid", int'(Out_Valid), 1);
      chk("put_hold_data", int'(Out_Data), 8'h41);
      chk("put_hold_nodone", int'(IOReady), 0);
    end
    Out_Ready = 1'b1;
    cyc(8'h40);
    chk("put_drop_valid", int'(Out_Valid), 0);
    chk("put_ioready", int'(IOReady), 1);
    Out_Ready = 1'b0;
    cyc(8'h40); chk("put_done_held", int'(IOReady), 1);
    cyc(8'h00); chk("put_done_exit", int'(IOReady), 0);

    cyc(8'hC0);
    chk("prio_put", int'(Out_Valid), 1);
    chk("prio_noget", int'(In_Ready), 0);
    Out_Ready = 1'b1;
    cyc(8'hC0); chk("prio_done", int'(IOReady), 1);
    Out_Ready = 1'b0;
    cyc(8'h00);

    cyc(8'h08);
    cyc(8'h10); chk("cell2_set", int'(State), 0);
    In_Valid = 1'b1; In_Data = 8'h00;
    cyc(8'h80); chk("get_ready", int'(In_Ready), 1);
    cyc(8'h80);
    chk("get_ready_drop", int'(In_Ready), 0);
    chk("get_ioready", int'(IOReady), 1);
    chk("get_state", int'(State), 1);
    cyc(8'h80); chk("get_done_held", int'(IOReady), 1);
    cyc(8'h81); chk("get_done_exit_pc", int'(IOReady), 0);
    In_Data = 8'h5A;
    cyc(8'h80); chk("get2_ready", int'(In_Ready), 1);
    cyc(8'h80);
    chk("get2_ioready", int'(IOReady), 1);
    chk("get2_state", int'(State), 0);
    cyc(8'h00);
    In_Valid = 1'b0;

    cyc(8'h04);
    cyc(8'h40); chk("abort_valid_pre", int'(Out_Valid), 1);
    #1 Reset_n = 1'b0;
    #1;
    chk("abort_valid", int'(Out_Valid), 0);
    chk("abort_ioready", int'(IOReady), 0);
    chk("abort_out_data", int'(Out_Data), 0);
    Command = 8'h00;
    @(posedge Clock); #2;
    Reset_n = 1'b1;
    #1 chk("abort_pc0", int'(Instruction), 0);
    for (int i = 0; i < TD; i++) begin
      chk("abort_tape_zero", int'(State), 1);
      cyc(8'h04);
    end

    ld_cnt = 0;
    repeat (3000) begin
      Out_Ready = 1'($urandom_range(0, 1));
      In_Valid  = 1'($urandom_range(0, 1));
      In_Data   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      if (ld_cnt == 0 && m_ph == 0 && $urandom_range(0, 99) == 0) ld_cnt = $urandom_range(1, 6);
      if (ld_cnt > 0) begin
        Load_En = 1'b1;
        Load_Addr = 6'($urandom);
        Load_Data = 4'($urandom);
        ld_cnt--;
      end else begin
        Load_En = 1'b0;
      end
      if (m_ph == 1 || m_ph == 2) begin
        cyc(Command & 8'hC0);
      end else begin
        r = $urandom_range(0, 3);
        case (r)
          0: cyc(8'h00);
          1: cyc(8'($urandom) & 8'h3F);
          2: cyc(8'($urandom));
          default: cyc(Command);
        endcase
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
